// File: rtl/spi_eeprom_responder.sv
`timescale 1ns/1ps
// SPI mode-0 responder emulating a 25xx serial EEPROM (READ/WRITE/WREN/WRDI/RDSR) on an internal byte array.
// Define SPI_EEPROM_PAGE_WRAP_EN to make write bursts wrap inside a PAGE_BYTES-aligned page.
module spi_eeprom_responder #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned PAGE_BYTES = 16,
  parameter string       INIT_FILE  = ""
) (
  input  logic        i_clk,
  input  logic        i_nReset,
  input  logic        i_spiCSn,
  input  logic        i_spiSCK,
  input  logic        i_spiMOSI,
  output logic        o_spiMISO,
  output logic        o_spiMISOEn,
  output logic        o_busy,
  output logic        o_wel,
  output logic [15:0] o_dbgAddr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RDDATA, S_WRDATA, S_STATUS, S_IGNORE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cs_sync, sck_sync;
  logic [1:0]        mosi_sync;
  logic              cs_fall, cs_rise, sck_rise, sck_fall;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        rx_q, tx_q, addr_hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_phase_q, rd_mode_q, wel_q, busy_q, miso_q, miso_en_q;
  logic [7:0]        mem [DEPTH];

  logic [7:0]        rx_byte, status_byte, tx_ld_val;
  logic [ADDR_W-1:0] addr_ld, addr_rd_next, addr_wr_next;
  logic              bit_shift, byte_done, rd_sel, wr_sel, wel_set, wel_clr;
  logic              addr_hi_ld, addr_lo_ld, rd_step, wr_step, mem_we, tx_ld;
  logic              tx_active, wel_drop;

  // Two-flop synchronisers; the third CSn/SCK stage is the previous level for edge detection
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      cs_sync   <= 3'b111;
      sck_sync  <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[1:0], i_spiCSn};
      sck_sync  <= {sck_sync[1:0], i_spiSCK};
      mosi_sync <= {mosi_sync[0], i_spiMOSI};
    end
  end

  assign cs_fall  = cs_sync[2] & ~cs_sync[1];
  assign cs_rise  = ~cs_sync[2] & cs_sync[1];
  assign sck_rise = ~sck_sync[2] & sck_sync[1];
  assign sck_fall = sck_sync[2] & ~sck_sync[1];

  assign rx_byte      = {rx_q[6:0], mosi_sync[1]};
  assign status_byte  = {6'b000000, wel_q, 1'b0};
  assign addr_ld      = ADDR_W'({addr_hi_q, rx_byte});
  assign addr_rd_next = addr_q + ADDR_W'(1);

`ifdef SPI_EEPROM_PAGE_WRAP_EN
  localparam int unsigned PAGE_W = $clog2(PAGE_BYTES);
  assign addr_wr_next = {addr_q[ADDR_W-1:PAGE_W], addr_q[PAGE_W-1:0] + PAGE_W'(1)};
`else
  assign addr_wr_next = addr_q + ADDR_W'(1);
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next state: CSn edges override everything, otherwise advance on completed bytes
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = S_IDLE;
    end else if (cs_fall) begin
      state_d = S_CMD;
    end else if (byte_done) begin
      case (state_q)
        S_CMD: begin
          if (rd_sel || wr_sel)        state_d = S_ADDR;
          else if (rx_byte == OP_RDSR) state_d = S_STATUS;
          else                         state_d = S_IGNORE;
        end
        S_ADDR:  if (addr_phase_q) state_d = rd_mode_q ? S_RDDATA : S_WRDATA;
        default: ;
      endcase
    end
  end

  // Per-cycle control strobes for the datapath
  always_comb begin
    bit_shift  = 1'b0;
    rd_sel     = 1'b0;
    wr_sel     = 1'b0;
    wel_set    = 1'b0;
    wel_clr    = 1'b0;
    addr_hi_ld = 1'b0;
    addr_lo_ld = 1'b0;
    rd_step    = 1'b0;
    wr_step    = 1'b0;
    mem_we     = 1'b0;
    tx_ld      = 1'b0;
    tx_ld_val  = 8'h00;
    tx_active  = (state_q == S_RDDATA) || (state_q == S_STATUS);
    wel_drop   = (state_q == S_WRDATA) || ((state_q == S_ADDR) && !rd_mode_q);
    if (sck_rise && !cs_fall && !cs_rise) begin
      case (state_q)
        S_CMD, S_ADDR, S_RDDATA, S_WRDATA, S_STATUS: bit_shift = 1'b1;
        default: ;
      endcase
    end
    byte_done = bit_shift && (bit_cnt_q == 3'd7);
    if (byte_done) begin
      case (state_q)
        S_CMD: begin
          case (rx_byte)
            OP_READ:  rd_sel  = 1'b1;
            OP_WRITE: wr_sel  = wel_q;
            OP_WREN:  wel_set = 1'b1;
            OP_WRDI:  wel_clr = 1'b1;
            OP_RDSR: begin
              tx_ld     = 1'b1;
              tx_ld_val = status_byte;
            end
            default: ;
          endcase
        end
        S_ADDR: begin
          if (!addr_phase_q) begin
            addr_hi_ld = 1'b1;
          end else begin
            addr_lo_ld = 1'b1;
            tx_ld      = rd_mode_q;
            tx_ld_val  = mem[addr_ld];
          end
        end
        S_RDDATA: begin
          rd_step   = 1'b1;
          tx_ld     = 1'b1;
          tx_ld_val = mem[addr_rd_next];
        end
        S_WRDATA: begin
          mem_we  = 1'b1;
          wr_step = 1'b1;
        end
        S_STATUS: begin
          tx_ld     = 1'b1;
          tx_ld_val = status_byte;
        end
        default: ;
      endcase
    end
  end

  // Shift registers, address pointer, WEL and pin drivers
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      bit_cnt_q    <= 3'd0;
      rx_q         <= 8'h00;
      tx_q         <= 8'h00;
      addr_hi_q    <= 8'h00;
      addr_q       <= '0;
      addr_phase_q <= 1'b0;
      rd_mode_q    <= 1'b0;
      wel_q        <= 1'b0;
      busy_q       <= 1'b0;
      miso_q       <= 1'b0;
      miso_en_q    <= 1'b0;
    end else if (cs_rise) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      busy_q    <= 1'b0;
      miso_q    <= 1'b0;
      miso_en_q <= 1'b0;
      if (wel_drop) wel_q <= 1'b0;
    end else if (cs_fall) begin
      bit_cnt_q    <= 3'd0;
      rx_q         <= 8'h00;
      tx_q         <= 8'h00;
      addr_phase_q <= 1'b0;
      busy_q       <= 1'b1;
      miso_q       <= 1'b0;
      miso_en_q    <= 1'b1;
    end else begin
      if (bit_shift) begin
        rx_q      <= rx_byte;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (wel_set) wel_q <= 1'b1;
      if (wel_clr) wel_q <= 1'b0;
      if (rd_sel)  rd_mode_q <= 1'b1;
      if (wr_sel)  rd_mode_q <= 1'b0;
      if (addr_hi_ld) begin
        addr_hi_q    <= rx_byte;
        addr_phase_q <= 1'b1;
      end
      if (addr_lo_ld) addr_q <= addr_ld;
      if (rd_step)    addr_q <= addr_rd_next;
      if (wr_step)    addr_q <= addr_wr_next;
      if (tx_ld) begin
        tx_q <= tx_ld_val;
      end else if (sck_fall && tx_active) begin
        tx_q <= {tx_q[6:0], 1'b0};
      end
      if (sck_fall) miso_q <= tx_active ? tx_q[7] : 1'b0;
    end
  end

  // Array has no reset so contents survive i_nReset
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[addr_q] <= rx_byte;
  end

  assign o_spiMISO   = miso_q;
  assign o_spiMISOEn = miso_en_q;
  assign o_busy      = busy_q;
  assign o_wel       = wel_q;
  assign o_dbgAddr   = 16'(addr_q);

endmodule
